// File: rtl/nibble_serial_adder.sv
// Multi-precision add/subtract engine: feeds a 4-bit ripple slice one nibble per cycle,
// least-significant first, with the inter-nibble carry held in a register.

module nibble_add_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);

    logic [4:0] carry;

    assign carry[0] = cin_i;

    for (genvar k = 0; k < 4; k++) begin : g_fa
        assign s_o[k]       = a_i[k] ^ b_i[k] ^ carry[k];
        assign carry[k + 1] = (a_i[k] & b_i[k]) | (carry[k] & (a_i[k] ^ b_i[k]));
    end

    assign cout_o = carry[4];

endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opA_q, opA_d;
    logic [W-1:0]    opB_q, opB_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   nibbleCnt_q, nibbleCnt_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [3:0]      sliceA;
    logic [3:0]      sliceB;
    logic [3:0]      sliceS;
    logic            sliceCout;

    always_comb begin
        sliceA = 4'b0;
        sliceB = 4'b0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (nibbleCnt_q == CW'(i)) begin
                sliceA = opA_q[4*i +: 4];
                sliceB = opB_q[4*i +: 4];
            end
        end
    end

    nibble_add_slice u_slice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .s_o    (sliceS),
        .cout_o (sliceCout)
    );

    // Subtraction is A + ~B + 1, so the inverted operand and forced carry are set up at accept.
    always_comb begin
        state_d     = state_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        carry_d     = carry_q;
        nibbleCnt_d = nibbleCnt_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    opA_d       = op_a;
                    opB_d       = sub ? ~op_b : op_b;
                    carry_d     = sub ? 1'b1 : cin;
                    nibbleCnt_d = '0;
                    sum_d       = '0;
                    cout_d      = 1'b0;
                    ovf_d       = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (nibbleCnt_q == CW'(i)) begin
                        sum_d[4*i +: 4] = sliceS;
                    end
                end
                carry_d = sliceCout;
                if (nibbleCnt_q == LAST) begin
                    cout_d  = sliceCout;
                    ovf_d   = (sliceA[3] == sliceB[3]) && (sliceS[3] != sliceA[3]);
                    state_d = DONE;
                end else begin
                    nibbleCnt_d = nibbleCnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            carry_q     <= 1'b0;
            nibbleCnt_q <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            carry_q     <= carry_d;
            nibbleCnt_q <= nibbleCnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder: a 4-nibble instance and a 1-nibble instance.

module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        start1;
    logic        sub1;
    logic        cin1;
    logic [3:0]  opA1;
    logic [3:0]  opB1;
    logic        busy1;
    logic        done1;
    logic [3:0]  sum1;
    logic        cout1;
    logic        ovf1;

    int vectors;
    int miscompares;
    int cycles;
    int busyCycles;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .op_a  (opA),
        .op_b  (opB),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .sub   (sub1),
        .cin   (cin1),
        .op_a  (opA1),
        .op_b  (opB1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .ovf   (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one operation for a single edge; returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
        @(negedge clk);
        start = 1'b1;
        opA   = a;
        opB   = b;
        sub   = s;
        cin   = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int nCycles, output int nBusy);
        nCycles = 0;
        nBusy   = 0;
        while (done !== 1'b1 && nCycles < 20) begin
            if (busy === 1'b1) nBusy++;
            @(negedge clk);
            nCycles++;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic s, input logic c,
                               input logic [15:0] expSum, input logic expCout, input logic expOvf);
        applyStimulus(a, b, s, c);
        waitDone(cycles, busyCycles);
        checkOutput({tag, "_latency"}, cycles, 4);
        checkOutput({tag, "_sum"}, sum, expSum);
        checkOutput({tag, "_cout"}, cout, expCout);
        checkOutput({tag, "_ovf"}, ovf, expOvf);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        cin    = 1'b0;
        opA    = '0;
        opB    = '0;
        start1 = 1'b0;
        sub1   = 1'b0;
        cin1   = 1'b0;
        opA1   = '0;
        opB1   = '0;

        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_ovf", ovf, 0);
        checkOutput("reset_sum1", sum1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add with busy/done timing
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        checkOutput("t1_busy_after_accept", busy, 1);
        waitDone(cycles, busyCycles);
        checkOutput("t1_latency", cycles, 4);
        checkOutput("t1_busy_cycles", busyCycles, 4);
        checkOutput("t1_sum", sum, 16'h5555);
        checkOutput("t1_cout", cout, 0);
        checkOutput("t1_ovf", ovf, 0);
        @(negedge clk);
        checkOutput("t1_done_pulse_end", done, 0);
        checkOutput("t1_sum_hold", sum, 16'h5555);

        runAndCheck("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runAndCheck("t2b", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        runAndCheck("t2c", 16'h0FFF, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
        runAndCheck("t3a", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        runAndCheck("t3b", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Start during RUN must be ignored
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        opA   = 16'hAAAA;
        opB   = 16'h5555;
        sub   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(cycles, busyCycles);
        checkOutput("t4_ignored_done", done, 1);
        checkOutput("t4_ignored_sum", sum, 16'h3333);
        checkOutput("t4_ignored_cout", cout, 0);
        @(negedge clk);
        checkOutput("t4_no_requeue", busy, 0);

        // Asynchronous reset mid-RUN
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t4_rst_busy", busy, 0);
        checkOutput("t4_rst_done", done, 0);
        checkOutput("t4_rst_sum", sum, 0);
        checkOutput("t4_rst_cout", cout, 0);
        checkOutput("t4_rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        runAndCheck("t4_fresh", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Back-to-back start held in DONE
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        waitDone(cycles, busyCycles);
        checkOutput("t5_first_sum", sum, 16'h5555);
        start = 1'b1;
        opA   = 16'h0001;
        opB   = 16'h0002;
        sub   = 1'b0;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t5_busy_again", busy, 1);
        checkOutput("t5_done_drop", done, 0);
        checkOutput("t5_sum_cleared", sum[15:4], 12'h000);
        waitDone(cycles, busyCycles);
        checkOutput("t5_latency", cycles, 4);
        checkOutput("t5_sum", sum, 16'h0003);

        // Single-nibble instance
        @(negedge clk);
        start1 = 1'b1;
        opA1   = 4'hF;
        opB1   = 4'h1;
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("t6a_busy", busy1, 1);
        @(negedge clk);
        checkOutput("t6a_done", done1, 1);
        checkOutput("t6a_sum", sum1, 4'h0);
        checkOutput("t6a_cout", cout1, 1);
        checkOutput("t6a_ovf", ovf1, 0);
        start1 = 1'b1;
        opA1   = 4'h7;
        opB1   = 4'h1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        checkOutput("t6b_done", done1, 1);
        checkOutput("t6b_sum", sum1, 4'h8);
        checkOutput("t6b_cout", cout1, 0);
        checkOutput("t6b_ovf", ovf1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
